// File: rtl/ps2_device_tx.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_device_tx
//  Purpose  : PS/2 device-side transmitter. Scancode bytes are queued in a
//             small FIFO and sent one frame at a time:
//             start(0), data[0..7] LSB first, odd parity, stop(1).
//             Each frame is followed by an idle gap.
//  Ports    : clk       - sole clock, rising edge
//             resetn    - asynchronous active-low reset
//             wr_en     - write strobe, one byte per cycle while high
//             wr_data   - scancode byte to queue
//             ps2_clk   - registered PS/2 clock output
//             ps2_data  - registered PS/2 data output
//             full      - FIFO holds FIFO_DEPTH entries
//             empty     - FIFO holds no entries
//             busy      - transmitter is sending or in its gap
//             overflow  - one-cycle pulse after a dropped write
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_device_tx #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       overflow
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_DIV_W = $clog2(2 * CLK_DIV);
    localparam int c_GAP_W = $clog2(GAP_CYCLES + 1);

    localparam logic [c_CNT_W-1:0] c_FIFO_FULL = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_DIV_W-1:0] c_DIV_HALF  = c_DIV_W'(CLK_DIV);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST  = c_DIV_W'(2 * CLK_DIV - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST  = c_GAP_W'(GAP_CYCLES - 1);
    localparam logic [3:0]         c_BIT_LAST  = 4'd10;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    // ------------------------------------------------------------------
    // Scancode FIFO
    // ------------------------------------------------------------------
    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_overflow;
    logic               w_push;
    logic               w_pop;
    logic [7:0]         w_head;

    assign full     = (r_count == c_FIFO_FULL);
    assign empty    = (r_count == '0);
    assign overflow = r_overflow;
    // Acceptance looks at the pre-pop fill level, so a write into a full
    // FIFO is dropped even when the transmitter pops on the same edge.
    assign w_push   = wr_en & ~full;
    assign w_head   = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_overflow <= wr_en & full;
        end
    end

    // Storage needs no reset: entries are only read once the count says so.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= wr_data;
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    logic [1:0]         r_state,    w_state_next;
    logic [c_DIV_W-1:0] r_div,      w_div_next;
    logic [3:0]         r_bit_idx,  w_bit_idx_next;
    logic [c_GAP_W-1:0] r_gap,      w_gap_next;
    logic [10:0]        r_frame,    w_frame_next;
    logic               r_ps2_clk,  w_ps2_clk_next;
    logic               r_ps2_data, w_ps2_data_next;
    logic [c_DIV_W-1:0] w_div_inc;

    assign w_div_inc = r_div + 1'b1;
    assign busy      = (r_state != S_IDLE);
    assign ps2_clk   = r_ps2_clk;
    assign ps2_data  = r_ps2_data;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_div      <= '0;
            r_bit_idx  <= '0;
            r_gap      <= '0;
            r_frame    <= '1;
            r_ps2_clk  <= 1'b1;
            r_ps2_data <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_div      <= w_div_next;
            r_bit_idx  <= w_bit_idx_next;
            r_gap      <= w_gap_next;
            r_frame    <= w_frame_next;
            r_ps2_clk  <= w_ps2_clk_next;
            r_ps2_data <= w_ps2_data_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_div_next      = r_div;
        w_bit_idx_next  = r_bit_idx;
        w_gap_next      = r_gap;
        w_frame_next    = r_frame;
        w_ps2_clk_next  = r_ps2_clk;
        w_ps2_data_next = r_ps2_data;
        w_pop           = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_ps2_clk_next  = 1'b1;
                w_ps2_data_next = 1'b1;
                if (!empty) begin
                    // Frame is held as a shift register; bit 0 is on the wire.
                    w_pop           = 1'b1;
                    w_frame_next    = {1'b1, ~^w_head, w_head, 1'b0};
                    w_state_next    = S_SEND;
                    w_div_next      = '0;
                    w_bit_idx_next  = '0;
                    w_ps2_data_next = 1'b0;
                end
            end

            S_SEND: begin
                if (r_div == c_DIV_LAST) begin
                    // Bit boundary: ps2_clk returns high, data moves here so
                    // it is settled well before the next falling edge.
                    w_div_next     = '0;
                    w_ps2_clk_next = 1'b1;
                    if (r_bit_idx == c_BIT_LAST) begin
                        w_state_next    = S_GAP;
                        w_gap_next      = '0;
                        w_ps2_data_next = 1'b1;
                    end else begin
                        w_bit_idx_next  = r_bit_idx + 1'b1;
                        w_frame_next    = {1'b1, r_frame[10:1]};
                        w_ps2_data_next = r_frame[1];
                    end
                end else begin
                    // Clock is derived from the next divider value so the
                    // registered output lines up with div exactly.
                    w_div_next     = w_div_inc;
                    w_ps2_clk_next = (w_div_inc < c_DIV_HALF);
                end
            end

            S_GAP: begin
                w_ps2_clk_next  = 1'b1;
                w_ps2_data_next = 1'b1;
                if (r_gap == c_GAP_LAST) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_gap_next = r_gap + 1'b1;
                end
            end

            default: begin
                w_state_next    = S_IDLE;
                w_ps2_clk_next  = 1'b1;
                w_ps2_data_next = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_device_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_device_tx
//  Purpose  : Self-checking bench for ps2_device_tx. A cycle-level reference
//             model predicts FIFO flags, overflow and the exact ps2_clk /
//             ps2_data waveform; a PS/2 receiver decodes frames on ps2_clk
//             falling edges and compares them with the bytes sent.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_device_tx;

    localparam int CLK_DIV    = 4;
    localparam int GAP_CYCLES = 16;
    localparam int FIFO_DEPTH = 8;
    localparam int FRAME_LEN  = 22 * CLK_DIV;
    localparam int BUSY_LEN   = FRAME_LEN + GAP_CYCLES;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       ps2_clk, ps2_data, full, empty, busy, overflow;

    ps2_device_tx #(
        .CLK_DIV   (CLK_DIV),
        .GAP_CYCLES(GAP_CYCLES),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .full    (full),
        .empty   (empty),
        .busy    (busy),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: queue of pending bytes and position in the
    // current transmission (-1 when idle).
    // ------------------------------------------------------------------
    logic [7:0] m_q[$];
    logic [7:0] exp_q[$];
    int         m_t = -1;
    logic [7:0] m_cur = 8'h00;
    logic       m_ovf = 1'b0;

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0)      return 1'b0;
        else if (k <= 8) return b[k-1];
        else if (k == 9) return ~^b;
        else             return 1'b1;
    endfunction

    task automatic model_edge();
        bit full_pre;
        full_pre = (m_q.size() == FIFO_DEPTH);
        m_ovf    = wr_en && full_pre;
        if (m_t < 0) begin
            if (m_q.size() != 0) begin
                m_cur = m_q.pop_front();
                exp_q.push_back(m_cur);
                m_t = 0;
            end
        end else if (m_t == BUSY_LEN - 1) begin
            m_t = -1;
        end else begin
            m_t++;
        end
        if (wr_en && !full_pre) m_q.push_back(wr_data);
    endtask

    task automatic model_reset();
        m_q.delete();
        exp_q.delete();
        m_t   = -1;
        m_ovf = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Receiver: sample data on every ps2_clk falling edge.
    // ------------------------------------------------------------------
    logic [10:0] rx_mem [1024];
    logic [10:0] mon_bits = '0;
    int          mon_n = 0;
    int          rx_wr = 0;
    int          rx_rd = 0;

    always @(negedge ps2_clk or negedge resetn) begin
        if (!resetn) begin
            mon_n = 0;
        end else begin
            mon_bits[mon_n] = ps2_data;
            mon_n++;
            if (mon_n == 11) begin
                rx_mem[rx_wr % 1024] = mon_bits;
                rx_wr++;
                mon_n = 0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle stepping and checking
    // ------------------------------------------------------------------
    int   cyc = 0;
    int   busy_cyc = 0;
    int   ovf_cnt = 0;
    int   rise_last = 0;
    int   rise_prev = 0;
    logic prev_busy = 1'b0;

    task automatic check_outputs();
        logic e_clk, e_data;
        int   bit_n, ph;
        if (m_t >= 0 && m_t < FRAME_LEN) begin
            bit_n  = m_t / (2 * CLK_DIV);
            ph     = m_t % (2 * CLK_DIV);
            e_clk  = (ph < CLK_DIV);
            e_data = frame_bit(m_cur, bit_n);
        end else begin
            e_clk  = 1'b1;
            e_data = 1'b1;
        end
        chk("ps2_clk",  32'(ps2_clk),  32'(e_clk));
        chk("ps2_data", 32'(ps2_data), 32'(e_data));
        chk("full",     32'(full),     32'(m_q.size() == FIFO_DEPTH));
        chk("empty",    32'(empty),    32'(m_q.size() == 0));
        chk("busy",     32'(busy),     32'(m_t >= 0));
        chk("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic check_frames();
        logic [10:0] f;
        logic [7:0]  b;
        while (rx_rd != rx_wr) begin
            f = rx_mem[rx_rd % 1024];
            if (exp_q.size() == 0) begin
                chk("rx_frame_expected", 32'(exp_q.size()), 32'd1);
            end else begin
                b = exp_q.pop_front();
                chk("rx_frame", 32'(f), 32'({1'b1, ~^b, b, 1'b0}));
            end
            rx_rd++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        if (busy) busy_cyc++;
        if (overflow) ovf_cnt++;
        if (busy && !prev_busy) begin
            rise_prev = rise_last;
            rise_last = cyc;
        end
        prev_busy = busy;
        check_outputs();
        check_frames();
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        wr_en = 1'b0;
        while ((m_t >= 0 || m_q.size() != 0) && n < 20000) begin
            step();
            n++;
        end
        chk("drain_timeout", 32'(n < 20000), 32'd1);
        repeat (3) step();
        chk("frames_outstanding", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        #1;
        model_reset();
        prev_busy = 1'b0;
        chk("rst_ps2_clk",  32'(ps2_clk),  32'd1);
        chk("rst_ps2_data", 32'(ps2_data), 32'd1);
        chk("rst_empty",    32'(empty),    32'd1);
        chk("rst_full",     32'(full),     32'd0);
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        rx_rd  = rx_wr;
    endtask

    initial begin
        int base;
        int n;

        #2;
        do_reset();
        repeat (4) step();

        // Single frame 0x1C: bit order, parity 0, busy length.
        base = rx_wr;
        busy_cyc = 0;
        write_byte(8'h1C);
        drain();
        chk("frames_1C", 32'(rx_wr - base), 32'd1);
        chk("frame_1C", 32'(rx_mem[(rx_wr - 1) % 1024]), 32'h438);
        chk("busy_len_1C", 32'(busy_cyc), 32'(BUSY_LEN));

        // 0x00 -> parity 1; 0xF0 -> parity 1.
        write_byte(8'h00);
        drain();
        chk("frame_00", 32'(rx_mem[(rx_wr - 1) % 1024]), 32'h600);
        write_byte(8'hF0);
        drain();
        chk("frame_F0", 32'(rx_mem[(rx_wr - 1) % 1024]), 32'h7E0);

        // Back-to-back bytes: start bits BUSY_LEN+1 cycles apart.
        base = rx_wr;
        wr_en = 1'b1; wr_data = 8'hF0; step();
        wr_data = 8'h1C; step();
        wr_en = 1'b0;
        drain();
        chk("frames_b2b", 32'(rx_wr - base), 32'd2);
        chk("start_spacing", 32'(rise_last - rise_prev), 32'(BUSY_LEN + 1));

        // Overflow: hold the FSM busy and push nine writes.
        base = rx_wr;
        write_byte(8'h55);
        step();
        ovf_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(8'hA0 + i);
            step();
            if (i == 7) chk("full_after_8", 32'(full), 32'd1);
        end
        wr_en = 1'b0;
        step();
        chk("overflow_pulses", 32'(ovf_cnt), 32'd1);
        drain();
        chk("frames_overflow", 32'(rx_wr - base), 32'd9);

        // Randomized traffic with alternating light and bursty phases.
        for (int i = 0; i < 3000; i++) begin
            int p;
            p       = ((i / 500) % 2 == 1) ? 60 : 3;
            wr_en   = ($urandom_range(0, 99) < p);
            wr_data = 8'($urandom);
            step();
        end
        wr_en = 1'b0;
        drain();

        // Reset in the middle of bit 5 with more bytes queued.
        write_byte(8'h3A);
        step();
        write_byte(8'h11);
        write_byte(8'h22);
        n = 0;
        while (m_t != 5 * 2 * CLK_DIV + CLK_DIV + 1 && n < 1000) begin
            step();
            n++;
        end
        chk("reach_bit5", 32'(n < 1000), 32'd1);
        chk("pre_rst_clk_low", 32'(ps2_clk), 32'd0);
        base = rx_wr;
        do_reset();

        // First write after release is accepted; nothing of the old frame.
        write_byte(8'hE0);
        chk("post_rst_empty", 32'(empty), 32'd0);
        drain();
        chk("frames_post_rst", 32'(rx_wr - base), 32'd1);
        chk("frame_E0", 32'(rx_mem[(rx_wr - 1) % 1024]), 32'({1'b1, 1'b0, 8'hE0, 1'b0}));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_device_tx.md
PS2_DEVICE_TX -- requirements
Module: ps2_device_tx

Interface
REQ-001 Parameter CLK_DIV, default 4: number of clk cycles per ps2_clk half-period; legal range 2..1023.
REQ-002 Parameter GAP_CYCLES, default 16: number of idle clk cycles inserted after every frame; legal range 1..1023.
REQ-003 Parameter FIFO_DEPTH, default 8: scancode FIFO depth; power of two, 2..16.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 resetn  input  1  asynchronous, active-low reset.
REQ-006 wr_en  input  1  write strobe; one byte is offered per cycle while high.
REQ-007 wr_data  input  8  scancode byte to transmit.
REQ-008 ps2_clk  output  1  device-generated PS/2 clock, registered.
REQ-009 ps2_data  output  1  device-generated PS/2 data, registered.
REQ-010 full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-011 empty  output  1  FIFO holds 0 entries.
REQ-012 busy  output  1  FSM is not in IDLE.
REQ-013 overflow  output  1  one-cycle pulse when a write is dropped.

Function
REQ-014 FIFO: first in, first out; pointer wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1.
REQ-015 A write is accepted when wr_en=1 and full=0 at that edge; it is evaluated on pre-pop state.
REQ-016 A write with full=1 is dropped, even if a pop happens in the same cycle; overflow=1 on the next cycle only.
REQ-017 When a push and a pop occur in the same cycle, count is unchanged and both operations take effect.
REQ-018 FSM states: IDLE, SEND, GAP.
REQ-019 IDLE: ps2_clk=1, ps2_data=1; when empty=0, pop the head byte and enter SEND on the same edge.
REQ-020 On entering SEND: latch the byte, set bit_idx=0, div=0, ps2_data=0 (start bit).
REQ-021 Frame order is: start=0, then data[0]..data[7] LSB first, then odd parity (XOR of data inverted), then stop=1.
REQ-022 SEND: div counts 0..2*CLK_DIV-1; ps2_clk=1 for div<CLK_DIV, otherwise 0; ps2_clk is registered so that it tracks div with no extra skew.
REQ-023 ps2_data changes only at div wrap, while ps2_clk is high, so it is stable across every ps2_clk falling edge.
REQ-024 At div wrap with bit_idx<10: bit_idx increments and ps2_data takes the next frame bit.
REQ-025 At div wrap with bit_idx=10: enter GAP with ps2_clk=1, ps2_data=1, gap counter=0.
REQ-026 One frame in SEND lasts exactly 22*CLK_DIV cycles and contains exactly 11 ps2_clk falling edges.
REQ-027 GAP lasts GAP_CYCLES cycles, then the FSM enters IDLE.
REQ-028 Back-to-back bytes: IDLE pops on the cycle after GAP ends, so consecutive start bits are separated by 22*CLK_DIV+GAP_CYCLES+1 cycles.
REQ-029 Writes are accepted in every state; an in-flight frame is never altered by FIFO activity.
REQ-030 busy=1 in SEND and GAP, and 0 in IDLE.

Reset
REQ-031 resetn=0 asynchronously forces: FSM=IDLE, ps2_clk=1, ps2_data=1, FIFO pointers and count=0, empty=1, full=0, busy=0, overflow=0, div/bit_idx/gap=0.
REQ-032 Reset mid-frame aborts the frame immediately; the FIFO contents are discarded.
REQ-033 After resetn deasserts, the first wr_en edge is accepted normally.

Verification
REQ-034 CLK_DIV=4: write 0x1C -> ps2_data values at the 11 ps2_clk falling edges are 0,0,0,1,1,1,0,0,0,0,1 (parity 0); busy is high for 88+GAP_CYCLES cycles.
REQ-035 Write 0x00 -> parity bit 1; write 0xF0 -> bits 0,0,0,0,0,1,1,1,1,1,1 (parity 1).
REQ-036 Write 0xF0 then 0x1C on consecutive cycles -> two frames in order; start bits are 22*CLK_DIV+GAP_CYCLES+1 cycles apart.
REQ-037 FIFO_DEPTH=8, FSM held busy: 9 writes -> full=1 after 8 writes; 9th write dropped with a single overflow pulse; exactly 8 frames are emitted.
REQ-038 Assert resetn=0 during bit_idx=5 -> ps2_clk=1, ps2_data=1 and empty=1 with no clock edge needed; no residual frame after release.
REQ-039 Loopback: connect ps2_clk/ps2_data to ps2_keyboard, send 0x1C,0xF0,0x1C -> the receiver reports 0x1C,0xF0,0x1C in order.
